// File: rtl/spi_fsm.sv
`default_nettype none
// ============================================================================
// Module   : spi_fsm
// Brief    : SPI memory peripheral transaction controller. Sequences the
//            shared shift register, address latch and data memory over one
//            chip-select frame (address+R/W field, then one data field).
// Options  : SPI_FSM_ABORT_FLAG_EN adds a sticky 'aborted' status output.
// Revision : 1.0 - initial release
// ============================================================================
module spi_fsm #(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic cs,
    input  logic sclkPosEdge,
    input  logic sclkNegEdge,
    input  logic rwBit,
    output logic addrWE,
    output logic srWE,
    output logic dmWE,
    output logic misoBufe,
    output logic busy
`ifdef SPI_FSM_ABORT_FLAG_EN
    ,
    output logic aborted
`endif
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] FIELD_BITS = CW'(WIDTH);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        GET_ADDR    = 3'd1,
        DECODE      = 3'd2,
        READ_LOAD   = 3'd3,
        READ_SHIFT  = 3'd4,
        WRITE_GET   = 3'd5,
        WRITE_STORE = 3'd6,
        DONE        = 3'd7
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [CW-1:0]   bit_count;
    logic [CW-1:0]   next_count;
    logic [CW-1:0]   count_inc;
    logic            next_addr_we;
    logic            next_sr_we;
    logic            next_dm_we;
    logic            next_miso_bufe;
    logic            next_busy;

    assign count_inc = bit_count + CW'(1);

    // Next-state, bit counter and Moore output decode (outputs follow the state being entered)
    always_comb begin
        next_state = state;
        next_count = bit_count;

        case (state)
            IDLE: begin
                next_count = '0;
                if (!cs) begin
                    next_state = GET_ADDR;
                end
            end
            GET_ADDR: begin
                if (sclkPosEdge) begin
                    next_count = count_inc;
                    if (count_inc == FIELD_BITS) begin
                        next_state = DECODE;
                    end
                end
            end
            DECODE: begin
                next_count = '0;
                next_state = rwBit ? READ_LOAD : WRITE_GET;
            end
            READ_LOAD: begin
                // Rising edges here belong to the shift register's load cycle, not the counter
                next_state = READ_SHIFT;
            end
            READ_SHIFT: begin
                if (sclkNegEdge) begin
                    next_count = count_inc;
                    if (count_inc == FIELD_BITS) begin
                        next_state = DONE;
                    end
                end
            end
            WRITE_GET: begin
                if (sclkPosEdge) begin
                    next_count = count_inc;
                    if (count_inc == FIELD_BITS) begin
                        next_state = WRITE_STORE;
                    end
                end
            end
            WRITE_STORE: begin
                next_state = DONE;
            end
            DONE: begin
                next_state = DONE;
            end
            default: begin
                next_state = IDLE;
                next_count = '0;
            end
        endcase

        // Chip-select release overrides any coincident SCLK activity
        if ((state != IDLE) && cs) begin
            next_state = IDLE;
            next_count = '0;
        end

        next_addr_we   = (next_state == DECODE);
        next_sr_we     = (next_state == READ_LOAD);
        next_dm_we     = (next_state == WRITE_STORE);
        next_miso_bufe = (next_state == READ_SHIFT);
        next_busy      = (next_state != IDLE);
    end

    // State, counter and registered output update
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            bit_count <= '0;
            addrWE    <= 1'b0;
            srWE      <= 1'b0;
            dmWE      <= 1'b0;
            misoBufe  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= next_state;
            bit_count <= next_count;
            addrWE    <= next_addr_we;
            srWE      <= next_sr_we;
            dmWE      <= next_dm_we;
            misoBufe  <= next_miso_bufe;
            busy      <= next_busy;
        end
    end

`ifdef SPI_FSM_ABORT_FLAG_EN
    logic abort_now;

    // A frame is aborted when cs rises before the controller reached DONE
    assign abort_now = cs && (state != IDLE) && (state != DONE);

    // Sticky abort flag, cleared when the next frame starts
    always_ff @(posedge clk) begin
        if (reset) begin
            aborted <= 1'b0;
        end else if (abort_now) begin
            aborted <= 1'b1;
        end else if ((state == IDLE) && !cs) begin
            aborted <= 1'b0;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_fsm
// Brief    : Self-checking bench for spi_fsm. Stimulus computes expected
//            output events from frame-level timing rules into a scoreboard;
//            a monitor compares observed events per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_fsm;

    localparam int WIDTH = 8;

    // Event kinds (one bit each, several may occur in one cycle)
    localparam int K_BUSY_UP = 1;
    localparam int K_BUSY_DN = 2;
    localparam int K_ADDR    = 4;
    localparam int K_SR      = 8;
    localparam int K_DM      = 16;
    localparam int K_MISO_UP = 32;
    localparam int K_MISO_DN = 64;
    localparam int K_AB_UP   = 128;
    localparam int K_AB_DN   = 256;

`ifdef SPI_FSM_ABORT_FLAG_EN
    localparam bit AB_EN = 1'b1;
`else
    localparam bit AB_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset, cs, sclkPosEdge, sclkNegEdge, rwBit;
    logic addrWE, srWE, dmWE, misoBufe, busy;
`ifdef SPI_FSM_ABORT_FLAG_EN
    logic aborted;
`endif

    spi_fsm #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .cs         (cs),
        .sclkPosEdge(sclkPosEdge),
        .sclkNegEdge(sclkNegEdge),
        .rwBit      (rwBit),
        .addrWE     (addrWE),
        .srWE       (srWE),
        .dmWE       (dmWE),
        .misoBufe   (misoBufe),
        .busy       (busy)
`ifdef SPI_FSM_ABORT_FLAG_EN
        ,
        .aborted    (aborted)
`endif
    );

    always #5 clk = ~clk;

    // Cycle index: inputs sampled at posedge N produce outputs tagged N
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;

    typedef struct {
        int cyc;
        int mask;
    } ev_t;
    ev_t sb[$];

    bit ab_flag = 1'b0;   // model of the sticky abort status

    function automatic int ab(input int k);
        return AB_EN ? k : 0;
    endfunction

    function automatic void check(input string name, input int act, input int req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s cyc=%0d actual=%03h required=%03h", name, cyc, act, req);
    endfunction

    // Insert expected events keeping the scoreboard ordered by cycle
    function automatic void expect_ev(input int c, input int m);
        ev_t e;
        int i;
        e.cyc  = c;
        e.mask = m;
        i = 0;
        while (i < sb.size() && sb[i].cyc <= c) i++;
        sb.insert(i, e);
    endfunction

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Monitor: derive events from DUT outputs and compare with scoreboard
    bit   mon_en = 1'b0;
    logic prev_busy, prev_miso, prev_ab;
    int   obs, exp_m;
    always @(negedge clk) begin
        if (mon_en) begin
            obs = 0;
            if (busy && !prev_busy)     obs |= K_BUSY_UP;
            if (!busy && prev_busy)     obs |= K_BUSY_DN;
            if (misoBufe && !prev_miso) obs |= K_MISO_UP;
            if (!misoBufe && prev_miso) obs |= K_MISO_DN;
            if (addrWE)                 obs |= K_ADDR;
            if (srWE)                   obs |= K_SR;
            if (dmWE)                   obs |= K_DM;
`ifdef SPI_FSM_ABORT_FLAG_EN
            if (aborted && !prev_ab)    obs |= K_AB_UP;
            if (!aborted && prev_ab)    obs |= K_AB_DN;
            prev_ab = aborted;
`endif
            exp_m = 0;
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                exp_m |= sb[0].mask;
                void'(sb.pop_front());
            end
            if (obs != 0 || exp_m != 0) check("events", obs, exp_m);
            prev_busy = busy;
            prev_miso = misoBufe;
        end
    end

    // One clk of stimulus; rwv < 0 drives a random rwBit
    task automatic tick(input bit p, input bit n, input bit c, input bit rst, input int rwv);
        sclkPosEdge = p;
        sclkNegEdge = n;
        cs          = c;
        reset       = rst;
        rwBit       = (rwv < 0) ? rb() : rwv[0];
        @(posedge clk);
        #1;
    endtask

    task automatic step(input bit p, input bit n, input bit c);
        tick(p, n, c, 1'b0, -1);
    endtask

    // mode: 0 normal, 1 cs rises with the last address edge,
    //       2 cs rises in the decode cycle, 3 reset after n_data data edges
    task automatic frame(input int n_addr, input bit rw, input int n_data, input int mode);
        int p8;
        repeat ($urandom_range(1, 3)) step(rb(), rb(), 1'b1);
        step(1'b0, 1'b0, 1'b0);
        expect_ev(cyc, K_BUSY_UP | (ab_flag ? ab(K_AB_DN) : 0));
        ab_flag = 1'b0;

        // Address field: rising edges count, falling edges are noise
        for (int i = 0; i < n_addr; i++) begin
            repeat ($urandom_range(0, 2)) step(1'b0, rb(), 1'b0);
            if (i == WIDTH - 1 && mode == 1) begin
                step(1'b1, rb(), 1'b1);
                expect_ev(cyc, K_BUSY_DN | ab(K_AB_UP));
                ab_flag = 1'b1;
                return;
            end
            step(1'b1, rb(), 1'b0);
        end
        if (n_addr < WIDTH) begin
            repeat ($urandom_range(0, 2)) step(1'b0, rb(), 1'b0);
            step(rb(), rb(), 1'b1);
            expect_ev(cyc, K_BUSY_DN | ab(K_AB_UP));
            ab_flag = 1'b1;
            return;
        end
        p8 = cyc;
        expect_ev(p8, K_ADDR);

        // Decode cycle: the only cycle in which rwBit is meaningful
        if (mode == 2) begin
            tick(rb(), rb(), 1'b1, 1'b0, int'(rw));
            expect_ev(cyc, K_BUSY_DN | ab(K_AB_UP));
            ab_flag = 1'b1;
            return;
        end
        tick(rb(), rb(), 1'b0, 1'b0, int'(rw));

        if (rw) begin
            expect_ev(p8 + 1, K_SR);
            expect_ev(p8 + 2, K_MISO_UP);
            step(rb(), 1'b0, 1'b0);
            for (int i = 0; i < n_data; i++) begin
                repeat ($urandom_range(0, 2)) step(rb(), 1'b0, 1'b0);
                step(rb(), 1'b1, 1'b0);
                if (i + 1 == WIDTH) expect_ev(cyc, K_MISO_DN);
            end
            if (mode == 3) begin
                tick(1'b0, 1'b0, 1'b1, 1'b1, -1);
                expect_ev(cyc, K_BUSY_DN | ((n_data < WIDTH) ? K_MISO_DN : 0));
                return;
            end
            if (n_data < WIDTH) begin
                step(rb(), rb(), 1'b1);
                expect_ev(cyc, K_BUSY_DN | K_MISO_DN | ab(K_AB_UP));
                ab_flag = 1'b1;
                return;
            end
        end else begin
            for (int i = 0; i < n_data; i++) begin
                repeat ($urandom_range(0, 2)) step(1'b0, rb(), 1'b0);
                step(1'b1, rb(), 1'b0);
                if (i + 1 == WIDTH) expect_ev(cyc, K_DM);
            end
            if (mode == 3) begin
                tick(1'b0, 1'b0, 1'b1, 1'b1, -1);
                expect_ev(cyc, K_BUSY_DN);
                return;
            end
            if (n_data < WIDTH) begin
                step(rb(), rb(), 1'b1);
                expect_ev(cyc, K_BUSY_DN | ab(K_AB_UP));
                ab_flag = 1'b1;
                return;
            end
        end

        // Completed frame: extra SCLK activity is ignored until cs rises
        repeat ($urandom_range(1, 3)) step(rb(), rb(), 1'b0);
        step(1'b0, 1'b0, 1'b1);
        expect_ev(cyc, K_BUSY_DN);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
        $fatal(1);
    end

    initial begin
        int n_addr, n_data, mode;
        sclkPosEdge = 1'b0;
        sclkNegEdge = 1'b0;
        cs          = 1'b1;
        rwBit       = 1'b0;
        reset       = 1'b1;
        @(posedge clk);
        #1;
        repeat (3) tick(rb(), rb(), 1'b0, 1'b1, -1);

        check("reset_outputs", int'({addrWE, srWE, dmWE, misoBufe, busy}), 0);
`ifdef SPI_FSM_ABORT_FLAG_EN
        check("reset_aborted", int'(aborted), 0);
`endif
        prev_busy = 1'b0;
        prev_miso = 1'b0;
        prev_ab   = 1'b0;
        mon_en    = 1'b1;

        frame(8, 1'b0, 8, 0);    // write frame 0xA4 then 0x3C
        frame(8, 1'b1, 8, 0);    // read frame 0x53
        frame(5, 1'b0, 0, 0);    // abort after 5 address bits
        frame(8, 1'b1, 3, 3);    // reset after 3 falling edges of a read
        frame(8, 1'b1, 8, 0);    // next frame 0x01 counts from bit 0
        frame(8, 1'b0, 20, 0);   // extra rising edges after the data field
        frame(8, 1'b0, 8, 1);    // cs rises with the 8th address edge
        frame(8, 1'b1, 8, 2);    // cs rises during decode
        frame(8, 1'b0, 8, 0);

        for (int f = 0; f < 40; f++) begin
            n_addr = ($urandom_range(0, 9) < 7) ? WIDTH : int'($urandom_range(0, WIDTH - 1));
            n_data = int'($urandom_range(0, 12));
            mode   = ($urandom_range(0, 9) < 7) ? 0 : int'($urandom_range(1, 3));
            frame(n_addr, rb(), n_data, mode);
        end

        repeat (4) step(1'b0, 1'b0, 1'b1);
        check("scoreboard_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_fsm.md
Name: spi_fsm

Overview:
Transaction controller for the SPI memory peripheral. It sequences the shared 8-bit shift register, the address latch and the data memory over one chip-select frame. A frame is address+R/W, then a data byte that is either received (write) or transmitted (read). Sits between the input synchronizers/edge detectors and the shift register/address latch/data memory/MISO tri-state buffer.

Parameters:
width, 8, bits per SPI field (address+R/W field and data field); counter sized $clog2(width+1)

Ports:
clk  input  1  system clock; single clock domain, all logic on posedge clk
reset  input  1  synchronous, active-high reset
cs  input  1  chip select, active low, already synchronized to clk
sclkPosEdge  input  1  one-clk pulse per rising SCLK edge (the shift register's peripheralClkEdge source)
sclkNegEdge  input  1  one-clk pulse per falling SCLK edge
rwBit  input  1  shift register parallelDataOut[0]; 1 = read, 0 = write; sampled in DECODE only
addrWE  output  1  one-cycle pulse; address latch captures parallelDataOut[width-1:1]
srWE  output  1  one-cycle pulse; drives the shift register parallelLoad from data memory
dmWE  output  1  one-cycle pulse; data memory write of parallelDataOut
misoBufe  output  1  MISO tri-state enable, level
busy  output  1  high in every state except IDLE

Behaviour:
- Registered Moore outputs. Reset (sync, reset=1 at posedge clk): state IDLE, bitCount 0, all outputs 0; reset beats every other input.
- States: IDLE, GET_ADDR, DECODE, READ_LOAD, READ_SHIFT, WRITE_GET, WRITE_STORE, DONE.
- IDLE: cs=0 -> GET_ADDR, bitCount cleared.
- GET_ADDR: bitCount++ per sclkPosEdge; on the pulse that makes bitCount==width -> DECODE next cycle, addrWE=1 for that one cycle (asserted in DECODE).
- DECODE (1 cycle): bitCount cleared; rwBit=1 -> READ_LOAD; rwBit=0 -> WRITE_GET.
- READ_LOAD (1 cycle): srWE=1. An sclkPosEdge pulse landing in this cycle is ignored by the counter. The shift register gives priority to its edge input, so the master must leave >=2 clk between the 8th rising edge and the next falling edge. Then -> READ_SHIFT.
- READ_SHIFT: misoBufe=1; bitCount++ per sclkNegEdge; after width falling edges -> DONE. misoBufe drops in the same cycle DONE is entered.
- WRITE_GET: bitCount++ per sclkPosEdge; at width -> WRITE_STORE.
- WRITE_STORE (1 cycle): dmWE=1, then -> DONE.
- DONE: all outputs 0, busy=1; extra SCLK edges ignored; cs=1 -> IDLE.
- Abort: cs=1 in any non-IDLE state -> IDLE next cycle, bitCount 0. cs wins over a coincident sclk pulse, so no addrWE/srWE/dmWE is issued for a partial field. An abort in DECODE/READ_LOAD/WRITE_STORE still lets that cycle's pulse complete (already registered). It then returns to 0.
- Simultaneous sclkPosEdge and sclkNegEdge: only the one relevant to the current state counts.
- bitCount never exceeds width; no wrap.
- Pulses: addrWE, srWE and dmWE are each exactly 1 clk wide and at most once per frame.

Optional Feature:
SPI_FSM_ABORT_FLAG_EN
- Defined: extra output port aborted (1 bit, reset 0). It is set the cycle after cs rises in GET_ADDR, DECODE, READ_LOAD, READ_SHIFT, WRITE_GET or WRITE_STORE. It is sticky until the next cs fall in IDLE or reset.
- Undefined: port absent; abort behaviour otherwise identical.

Test Plan:
- Write frame: cs=0, shift 0xA4 (addr 0x52, rw=0), then 0x3C, cs=1 -> addrWE pulse once after 8th posedge; dmWE single pulse after 16th posedge; misoBufe stays 0; busy 1->0 after cs=1.
- Read frame: shift 0x53 (addr 0x29, rw=1) -> addrWE, then srWE in the following cycle; misoBufe=1 for exactly 8 sclkNegEdge pulses then 0; dmWE never asserts.
- Abort after 5 address bits: cs=1 -> state IDLE next clk, no addrWE; with SPI_FSM_ABORT_FLAG_EN aborted=1 until next cs fall.
- Reset mid-READ_SHIFT (after 3 neg edges): reset=1 one clk -> all outputs 0, busy 0; next frame with 0x01 counts from bit 0 correctly.
- Extra clocks: 20 posedges in a write frame -> dmWE exactly once, remaining edges ignored in DONE.
- Coincident cs=1 and 8th sclkPosEdge in GET_ADDR -> IDLE, addrWE stays 0.
